mem_stage: RTL and testbench

- Memory-access pipeline stage directly downstream of the execute stage.
- Consumes the EX results: ALU result as address, store data, load type, control bits, write register, PC, hiloData and the exception code.
- Drives an SRAM-like data bus (req/addr_ok/data_ok) through a small request FSM, then aligns and extends load data.
- Registers the write-back bundle for WB and raises stall while a bus transaction is outstanding.

---
 rtl/mem_pkg.sv | 28 ++
 rtl/mem_stage_if.sv | 23 ++
 rtl/mem_load_ext.sv | 27 ++
 rtl/mem_stage.sv | 157 +++++++++++++++
 tb/tb_mem_stage.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the memory-access stage: bus size codes, exception codes,
// request FSM states and the store-lane replication helper.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [2:0] EXC_NONE = 3'd0;
    localparam logic [2:0] EXC_ADEL = 3'd4;
    localparam logic [2:0] EXC_ADES = 3'd5;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } state_e;

    // Stores drive every byte lane so the memory can pick the lane from the address.
    function automatic logic [31:0] lane_replicate(input logic [1:0] size, input logic [31:0] d);
        case (size)
            SZ_BYTE: return {4{d[7:0]}};
            SZ_HALF: return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// SRAM-like data bus between the memory stage (master) and the data memory (slave).
interface mem_stage_if;

    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic [31:0] data_rdata;
    logic        data_data_ok;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wdata,
        input  data_addr_ok, data_rdata, data_data_ok
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wdata,
        output data_addr_ok, data_rdata, data_data_ok
    );

endinterface

// File: rtl/mem_load_ext.sv
// Load-data aligner: selects the byte/half lane from the low address bits and
// sign- or zero-extends it to 32 bits.
module mem_load_ext
    import mem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_i,
    input  logic [2:0]  MemReadType_i,
    output logic [31:0] value_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic        zext;

    always_comb begin
        byte_v = 8'(rdata_i >> {addr_i, 3'b000});
        half_v = 16'(rdata_i >> {addr_i[1], 4'b0000});
        zext   = MemReadType_i[2];
        case (MemReadType_i[1:0])
            SZ_BYTE: value_o = zext ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
            SZ_HALF: value_o = zext ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
            default: value_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues data-bus requests, aligns load data and
// registers the write-back bundle. Optional MEM_ADDR_EXC_EN adds misalignment exceptions.
module mem_stage
    import mem_pkg::*;
#(
    parameter int unsigned REG_W = 7,
    parameter int unsigned EXC_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_i,
    input  logic               flush,
    input  logic               RegWrite_i,
    input  logic               MemtoReg_i,
    input  logic               MemWrite_i,
    input  logic               MemRead_i,
    input  logic [2:0]         MemReadType_i,
    input  logic [31:0]        ALUResult,
    input  logic [31:0]        MemData_i,
    input  logic [REG_W-1:0]   WriteRegister_i,
    input  logic [31:0]        PCin,
    input  logic [EXC_W-1:0]   exception_i,
    input  logic               hiloWrite_i,
    input  logic [63:0]        hiloData_i,
    mem_stage_if.master        dbus,
    output logic               stall,
    output logic               valid_o,
    output logic               RegWrite_o,
    output logic [REG_W-1:0]   WriteRegister_o,
    output logic [31:0]        WriteData_o,
    output logic               hiloWrite_o,
    output logic [63:0]        hiloData_o,
    output logic [31:0]        PCout,
    output logic [EXC_W-1:0]   exception_o,
    output logic [31:0]        badvaddr_o
);

    state_e state_q, state_d;
    logic   discard_q, discard_d;
    logic   is_mem, up_exc, addr_exc, memop;
    logic   req, stall_c, load, commit;
    logic   [EXC_W-1:0] exc_d;
    logic   [31:0] badv_d;
    logic   [31:0] load_val;

    assign is_mem = MemRead_i | MemWrite_i;
    assign up_exc = exception_i != '0;

`ifdef MEM_ADDR_EXC_EN
    logic misalign;
    assign misalign = ((MemReadType_i[1:0] == SZ_HALF) & ALUResult[0]) |
                      ((MemReadType_i[1:0] == SZ_WORD) & (ALUResult[1:0] != 2'b00));
    assign addr_exc = valid_i & is_mem & !up_exc & misalign;
    assign badv_d   = addr_exc ? ALUResult : '0;
`else
    assign addr_exc = 1'b0;
    assign badv_d   = '0;
`endif

    assign memop = valid_i & is_mem & !up_exc & !addr_exc & !flush;

    always_comb begin
        if (up_exc)        exc_d = exception_i;
        else if (addr_exc) exc_d = MemRead_i ? EXC_W'(EXC_ADEL) : EXC_W'(EXC_ADES);
        else               exc_d = EXC_W'(EXC_NONE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            discard_q <= discard_d;
        end
    end

    // A flush after acceptance cannot cancel the bus transfer; it only marks the result as a bubble.
    always_comb begin
        state_d   = state_q;
        discard_d = discard_q;
        req       = 1'b0;
        stall_c   = 1'b0;
        load      = 1'b0;
        case (state_q)
            IDLE: begin
                req       = memop;
                stall_c   = memop;
                discard_d = 1'b0;
                if (memop) state_d = dbus.data_addr_ok ? WAIT : REQ;
                else       load    = 1'b1;
            end
            REQ: begin
                req     = 1'b1;
                stall_c = 1'b1;
                if (dbus.data_addr_ok) begin
                    state_d   = WAIT;
                    discard_d = flush;
                end else if (flush) begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (dbus.data_data_ok) begin
                    state_d   = IDLE;
                    discard_d = 1'b0;
                    load      = 1'b1;
                end else begin
                    stall_c = 1'b1;
                    if (flush) discard_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign commit = load & valid_i & !flush & !discard_q;
    assign stall  = stall_c;

    assign dbus.data_req   = req;
    assign dbus.data_wr    = MemWrite_i;
    assign dbus.data_size  = MemReadType_i[1:0];
    assign dbus.data_addr  = ALUResult;
    assign dbus.data_wdata = lane_replicate(MemReadType_i[1:0], MemData_i);

    mem_load_ext u_load_ext (
        .rdata_i       (dbus.data_rdata),
        .addr_i        (ALUResult[1:0]),
        .MemReadType_i (MemReadType_i),
        .value_o       (load_val)
    );

    always_ff @(posedge clk) begin
        if (!rst || !commit) begin
            valid_o         <= 1'b0;
            RegWrite_o      <= 1'b0;
            WriteRegister_o <= '0;
            WriteData_o     <= '0;
            hiloWrite_o     <= 1'b0;
            hiloData_o      <= '0;
            PCout           <= '0;
            exception_o     <= '0;
            badvaddr_o      <= '0;
        end else begin
            valid_o         <= 1'b1;
            RegWrite_o      <= RegWrite_i & !up_exc & !addr_exc;
            WriteRegister_o <= WriteRegister_i;
            WriteData_o     <= MemtoReg_i ? load_val : ALUResult;
            hiloWrite_o     <= hiloWrite_i & !up_exc & !addr_exc;
            hiloData_o      <= hiloData_i;
            PCout           <= PCin;
            exception_o     <= exc_d;
            badvaddr_o      <= badv_d;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage; the bench plays the data memory
// with configurable addr_ok/data_ok latencies.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i, flush, RegWrite_i, MemtoReg_i, MemWrite_i, MemRead_i;
    logic [2:0]  MemReadType_i;
    logic [31:0] ALUResult, MemData_i, PCin;
    logic [6:0]  WriteRegister_i;
    logic [2:0]  exception_i;
    logic        hiloWrite_i;
    logic [63:0] hiloData_i;
    logic        stall, valid_o, RegWrite_o, hiloWrite_o;
    logic [6:0]  WriteRegister_o;
    logic [31:0] WriteData_o, PCout, badvaddr_o;
    logic [63:0] hiloData_o;
    logic [2:0]  exception_o;

    int n_chk  = 0;
    int n_fail = 0;
    int nstall, nreq;

    mem_stage_if bus ();

    mem_stage #(.REG_W(7), .EXC_W(3)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .flush(flush),
        .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i), .MemWrite_i(MemWrite_i),
        .MemRead_i(MemRead_i), .MemReadType_i(MemReadType_i), .ALUResult(ALUResult),
        .MemData_i(MemData_i), .WriteRegister_i(WriteRegister_i), .PCin(PCin),
        .exception_i(exception_i), .hiloWrite_i(hiloWrite_i), .hiloData_i(hiloData_i),
        .dbus(bus.master), .stall(stall), .valid_o(valid_o), .RegWrite_o(RegWrite_o),
        .WriteRegister_o(WriteRegister_o), .WriteData_o(WriteData_o),
        .hiloWrite_o(hiloWrite_o), .hiloData_o(hiloData_o), .PCout(PCout),
        .exception_o(exception_o), .badvaddr_o(badvaddr_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic clr_in();
        valid_i = 0; flush = 0; RegWrite_i = 0; MemtoReg_i = 0; MemWrite_i = 0;
        MemRead_i = 0; MemReadType_i = 3'b010; ALUResult = '0; MemData_i = '0;
        WriteRegister_i = '0; PCin = '0; exception_i = '0; hiloWrite_i = 0; hiloData_i = '0;
        bus.data_addr_ok = 0; bus.data_data_ok = 0; bus.data_rdata = '0;
    endtask

    task automatic next();
        @(posedge clk); #1;
    endtask

    task automatic set_mem(input logic rd, input logic [2:0] typ, input logic [31:0] addr,
                           input logic [31:0] wd);
        valid_i = 1; MemRead_i = rd; MemWrite_i = !rd; MemtoReg_i = rd; RegWrite_i = rd;
        MemReadType_i = typ; ALUResult = addr; MemData_i = wd;
        WriteRegister_i = 7'd9; PCin = 32'hBFC0_0100;
    endtask

    task automatic set_alu(input logic [31:0] val, input logic [6:0] rd);
        valid_i = 1; RegWrite_i = 1; ALUResult = val; WriteRegister_i = rd;
        PCin = 32'hBFC0_0200; hiloWrite_i = 1; hiloData_i = 64'h1111_2222_3333_4444;
    endtask

    // Plays the memory side: addr_ok a_dly cycles after the first request cycle,
    // data_ok d_dly cycles after that; optional one-cycle flush at cycle flush_at.
    task automatic txn(input int a_dly, input int d_dly, input int flush_at,
                       input logic [31:0] rdata, input logic [1:0] esz, input logic ewr,
                       input logic [31:0] ewdata, output int ns, output int nr);
        ns = 0; nr = 0;
        for (int c = 0; c <= a_dly + d_dly; c++) begin
            bus.data_addr_ok = (c == a_dly);
            bus.data_data_ok = (c == a_dly + d_dly);
            bus.data_rdata   = (c == a_dly + d_dly) ? rdata : 32'h0BAD_F00D;
            flush            = (c == flush_at);
            @(negedge clk);
            if (bus.data_req) nr++;
            if (stall) ns++;
            if (c == 0) begin
                check("bus_addr", bus.data_addr, ALUResult);
                check("bus_size", bus.data_size, esz);
                check("bus_wr", bus.data_wr, ewr);
                check("bus_wdata", bus.data_wdata, ewdata);
            end
            next();
        end
        clr_in();
    endtask

    task automatic load_case(input string tag, input logic [2:0] typ, input logic [31:0] addr,
                             input logic [31:0] rdata, input logic [31:0] exp);
        set_mem(1, typ, addr, '0);
        txn(0, 1, -1, rdata, typ[1:0], 1'b0, '0, nstall, nreq);
        check({tag, "_data"}, WriteData_o, exp);
        check({tag, "_valid"}, valid_o, 1);
        check({tag, "_stall"}, nstall, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        clr_in();
        rst = 0;
        next(); next();
        check("rst_valid", valid_o, 0);
        check("rst_regw", RegWrite_o, 0);
        check("rst_pc", PCout, 0);
        check("rst_req", bus.data_req, 0);
        check("rst_stall", stall, 0);
        rst = 1;

        set_alu(32'h0000_1234, 7'd3);
        @(negedge clk);
        check("alu_stall", stall, 0);
        check("alu_req", bus.data_req, 0);
        next();
        check("alu_valid", valid_o, 1);
        check("alu_regw", RegWrite_o, 1);
        check("alu_data", WriteData_o, 32'h0000_1234);
        check("alu_wreg", WriteRegister_o, 7'd3);
        check("alu_pc", PCout, 32'hBFC0_0200);
        check("alu_hilo", hiloData_o, 64'h1111_2222_3333_4444);
        check("alu_hilow", hiloWrite_o, 1);
        clr_in();

        load_case("lb", 3'b000, 32'h8000_0003, 32'h80AA_BBCC, 32'hFFFF_FF80);
        load_case("lbu", 3'b100, 32'h8000_0003, 32'h80AA_BBCC, 32'h0000_0080);
        load_case("lbu1", 3'b100, 32'h8000_0001, 32'h80AA_BBCC, 32'h0000_00BB);
        load_case("lh", 3'b001, 32'h8000_0002, 32'h8001_7FFF, 32'hFFFF_8001);
        load_case("lhu", 3'b101, 32'h8000_0000, 32'h8001_7FFF, 32'h0000_7FFF);
        check("ld_regw", RegWrite_o, 1);

        set_mem(0, 3'b001, 32'h1000_0002, 32'h0000_1234);
        txn(0, 1, -1, '0, 2'd1, 1'b1, 32'h1234_1234, nstall, nreq);
        check("sh_valid", valid_o, 1);
        check("sh_regw", RegWrite_o, 0);

        set_mem(1, 3'b010, 32'h0000_0040, '0);
        txn(3, 2, -1, 32'hDEAD_BEEF, 2'd2, 1'b0, '0, nstall, nreq);
        check("lw_stalls", nstall, 5);
        check("lw_reqs", nreq, 4);
        check("lw_data", WriteData_o, 32'hDEAD_BEEF);
        check("lw_wreg", WriteRegister_o, 7'd9);

        set_mem(1, 3'b010, 32'h0000_0044, '0);
        txn(0, 3, 1, 32'h5555_AAAA, 2'd2, 1'b0, '0, nstall, nreq);
        check("fw_stalls", nstall, 3);
        check("fw_valid", valid_o, 0);
        check("fw_regw", RegWrite_o, 0);
        set_alu(32'h0000_0077, 7'd4);
        @(negedge clk);
        check("fw_next_stall", stall, 0);
        next();
        check("fw_next_valid", valid_o, 1);
        check("fw_next_data", WriteData_o, 32'h0000_0077);
        clr_in();

        set_mem(1, 3'b010, 32'h0000_0048, '0);
        @(negedge clk);
        check("fr_req0", bus.data_req, 1);
        next();
        flush = 1;
        @(negedge clk);
        check("fr_req1", bus.data_req, 1);
        next();
        clr_in();
        @(negedge clk);
        check("fr_idle_req", bus.data_req, 0);
        check("fr_idle_stall", stall, 0);
        check("fr_valid", valid_o, 0);
        next();

        set_mem(1, 3'b010, 32'h0000_0050, '0);
        exception_i = 3'd2;
        @(negedge clk);
        check("exc_req", bus.data_req, 0);
        check("exc_stall", stall, 0);
        next();
        check("exc_valid", valid_o, 1);
        check("exc_code", exception_o, 3'd2);
        check("exc_regw", RegWrite_o, 0);
        clr_in();

        set_alu(32'h0000_0099, 7'd6);
        flush = 1;
        @(negedge clk);
        check("fi_stall", stall, 0);
        next();
        check("fi_valid", valid_o, 0);
        check("fi_regw", RegWrite_o, 0);
        clr_in();

`ifdef MEM_ADDR_EXC_EN
        set_mem(1, 3'b010, 32'h0000_0102, '0);
        @(negedge clk);
        check("adel_req", bus.data_req, 0);
        check("adel_stall", stall, 0);
        next();
        check("adel_code", exception_o, 3'd4);
        check("adel_badv", badvaddr_o, 32'h0000_0102);
        check("adel_regw", RegWrite_o, 0);
        check("adel_valid", valid_o, 1);
        set_mem(0, 3'b001, 32'h0000_0101, 32'h0000_00AB);
        @(negedge clk);
        check("ades_req", bus.data_req, 0);
        next();
        check("ades_code", exception_o, 3'd5);
        check("ades_badv", badvaddr_o, 32'h0000_0101);
        clr_in();
`else
        set_mem(1, 3'b010, 32'h0000_0102, '0);
        @(negedge clk);
        check("mis_req", bus.data_req, 1);
        txn(0, 1, -1, 32'hCAFE_F00D, 2'd2, 1'b0, '0, nstall, nreq);
        check("mis_data", WriteData_o, 32'hCAFE_F00D);
        check("mis_code", exception_o, 3'd0);
        check("mis_badv", badvaddr_o, 32'h0);
`endif

        set_mem(1, 3'b010, 32'h0000_0060, '0);
        bus.data_addr_ok = 1;
        next();
        bus.data_addr_ok = 0;
        rst = 0;
        next();
        rst = 1;
        clr_in();
        check("rw_valid", valid_o, 0);
        check("rw_data", WriteData_o, 0);
        @(negedge clk);
        check("rw_stall", stall, 0);
        check("rw_req", bus.data_req, 0);
        set_alu(32'h0000_0123, 7'd2);
        @(negedge clk);
        check("rw_alu_stall", stall, 0);
        next();
        check("rw_alu_valid", valid_o, 1);
        check("rw_alu_data", WriteData_o, 32'h0000_0123);
        clr_in();
        next();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
